// File: rtl/dct2_pkg.sv
// Shared types and helpers for the DCT-II output permutation stream.
// DCT2_ZERO_OUT_EN: for N=64 only frequencies 0..31 are emitted.
package dct2_pkg;

    localparam int MIN_LOG2N = 2;
    localparam int IDXW      = 8;

    typedef logic [2:0]      log2n_t;
    typedef logic [IDXW-1:0] idx_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // Butterfly slot holding frequency k of a size 2^log2n transform.
    function automatic idx_t perm_slot(input idx_t k, input log2n_t log2n);
        idx_t n;
        idx_t m;
        int   t;
        n = idx_t'(1) << log2n;
        t = 0;
        for (int i = IDXW - 1; i >= 0; i--) begin
            if (k[i]) t = i;
        end
        m = n >> (t + 1);
        if (k == '0) return '0;
        return m + (k >> (t + 1));
    endfunction

    // Number of frequencies emitted for a block of size 2^log2n.
    function automatic idx_t emit_count(input log2n_t log2n);
`ifdef DCT2_ZERO_OUT_EN
        if (log2n == 3'd6) return idx_t'(32);
`endif
        return idx_t'(1) << log2n;
    endfunction

endpackage

// File: rtl/dct2_perm_map.sv
// Combinational lane-to-slot map: for one output beat, the butterfly slot
// feeding each lane and whether that lane carries a real frequency.
module dct2_perm_map
    import dct2_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic [IDXW-1:0]       beat,
    input  logic [2:0]            log2n,
    output logic [LANES*IDXW-1:0] slots,
    output logic [LANES-1:0]      lane_en
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            idx_t k;
            assign k = IDXW'(int'(beat) * LANES + gi);
            assign slots[gi*IDXW +: IDXW] = perm_slot(k, log2n);
            assign lane_en[gi] = (k < emit_count(log2n));
        end
    endgenerate

endmodule

// File: rtl/dct2_perm_stream.sv
// Reorders DCT-II butterfly outputs into frequency order, LANES per beat.
// DCT2_ZERO_OUT_EN (see dct2_pkg): N=64 blocks stop after frequency 31.
module dct2_perm_stream
    import dct2_pkg::*;
#(
    parameter int DW        = 16,
    parameter int MAX_LOG2N = 6,
    parameter int LANES     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_log2n,
    input  logic [DW*(1<<MAX_LOG2N)-1:0]  in_coef,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DW*LANES-1:0]           out_coef,
    output logic                          out_last,
    output logic                          cfg_err
);

    localparam int CW = DW * (1 << MAX_LOG2N);

    function automatic idx_t last_beat(input log2n_t l);
        idx_t e;
        e = emit_count(l);
        if (int'(e) <= LANES) return '0;
        return idx_t'(int'(e) / LANES - 1);
    endfunction

    state_t                state_reg, state_next;
    logic [CW-1:0]         buf_reg;
    log2n_t                log2n_reg;
    idx_t                  beat_reg;
    logic [DW*LANES-1:0]   out_coef_reg;
    logic                  out_last_reg;
    logic                  cfg_err_reg;

    logic                  take, final_beat, accept, bad_log2n;
    log2n_t                log2n_eff;
    idx_t                  sel_beat;
    log2n_t                sel_log2n;
    logic [CW-1:0]         sel_src;
    logic [LANES*IDXW-1:0] slots;
    logic [LANES-1:0]      lane_en;
    logic [DW*LANES-1:0]   lane_data;

    assign bad_log2n  = (in_log2n < 3'(MIN_LOG2N)) || (in_log2n > 3'(MAX_LOG2N));
    assign log2n_eff  = bad_log2n ? log2n_t'(MAX_LOG2N) : in_log2n;
    assign take       = (state_reg == ST_SEND) && out_ready;
    assign final_beat = (beat_reg == last_beat(log2n_reg));
    assign in_ready   = (state_reg == ST_IDLE) || (take && final_beat);
    assign accept     = in_valid && in_ready;

    // Next beat is built from the incoming block on accept so data is ready one cycle later.
    assign sel_beat  = accept ? '0 : beat_reg + 1'b1;
    assign sel_log2n = accept ? log2n_eff : log2n_reg;
    assign sel_src   = accept ? in_coef : buf_reg;

    dct2_perm_map #(
        .LANES (LANES)
    ) u_map (
        .beat    (sel_beat),
        .log2n   (sel_log2n),
        .slots   (slots),
        .lane_en (lane_en)
    );

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            idx_t slot;
            assign slot = slots[gi*IDXW +: IDXW];
            assign lane_data[gi*DW +: DW] = lane_en[gi] ? sel_src[int'(slot)*DW +: DW] : '0;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_SEND;
            ST_SEND: if (take && final_beat && !accept) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (accept) buf_reg <= in_coef;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log2n_reg    <= '0;
            beat_reg     <= '0;
            out_coef_reg <= '0;
            out_last_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            cfg_err_reg <= accept && bad_log2n;
            if (accept) begin
                log2n_reg    <= log2n_eff;
                beat_reg     <= '0;
                out_coef_reg <= lane_data;
                out_last_reg <= (last_beat(log2n_eff) == '0);
            end else if (take) begin
                if (final_beat) begin
                    out_coef_reg <= '0;
                    out_last_reg <= 1'b0;
                end else begin
                    beat_reg     <= beat_reg + 1'b1;
                    out_coef_reg <= lane_data;
                    out_last_reg <= (beat_reg + 1'b1 == last_beat(log2n_reg));
                end
            end
        end
    end

    assign out_valid = (state_reg == ST_SEND);
    assign out_coef  = out_coef_reg;
    assign out_last  = out_last_reg;
    assign cfg_err   = cfg_err_reg;

endmodule
